riscv_mc_ctrl: RTL

Multicycle control unit for the RV32I core. It sequences one shared ALU, register file and unified instruction/data memory across several cycles per instruction, replacing the single-cycle decoder. It is a Moore FSM with a ready/req handshake toward memory, a sticky trap on unsupported opcodes, and a retired-instruction counter. It sits beside the multicycle datapath, which holds the PC, OldPC, IR, A, WriteData, ALUOut and Data registers.

---
 rtl/riscv_mc_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multicycle RV32I control FSM with memory handshake, sticky trap and retired-instruction counter
module riscv_mc_ctrl #(
  parameter int XLen = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [6:0]      op_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7b5_i,
  input  logic            zero_i,
  input  logic            mem_ready_i,
  output logic            mem_req_o,
  output logic            mem_write_o,
  output logic            adr_src_o,
  output logic            ir_write_o,
  output logic            pc_write_o,
  output logic            reg_write_o,
  output logic [1:0]      result_src_o,
  output logic [1:0]      alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic [2:0]      alu_control_o,
  output logic [2:0]      imm_src_o,
  output logic            illegal_o,
  output logic [XLen-1:0] instret_o
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, LUI, TRAP
  } state_t;
  state_t state, state_next;
  logic [2:0] alu_f3;
  logic retire;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= FETCH;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      FETCH:    state_next = mem_ready_i ? DECODE : FETCH;
      DECODE:   state_next = (op_i == 7'b0000011 || op_i == 7'b0100011) ? MEMADR :
                             op_i == 7'b0110011 ? EXECR :
                             op_i == 7'b0010011 ? EXECI :
                             op_i == 7'b1100011 ? BEQ :
                             op_i == 7'b1101111 ? JAL :
                             op_i == 7'b0110111 ? LUI : TRAP;
      MEMADR:   state_next = op_i == 7'b0000011 ? MEMREAD : MEMWRITE;
      MEMREAD:  state_next = mem_ready_i ? MEMWB : MEMREAD;
      MEMWRITE: state_next = mem_ready_i ? FETCH : MEMWRITE;
      EXECR, EXECI, JAL, LUI: state_next = ALUWB;
      MEMWB, ALUWB, BEQ: state_next = FETCH;
      default:  state_next = TRAP;
    endcase
  end
  // Shared funct3 decode; only the 000 case differs between R-type and I-type
  always_comb
    alu_f3 = funct3_i == 3'b111 ? 3'b010 :
             funct3_i == 3'b110 ? 3'b011 :
             funct3_i == 3'b100 ? 3'b100 :
             funct3_i == 3'b010 ? 3'b101 : 3'b000;
  always_comb begin
    mem_req_o     = 1'b0;
    mem_write_o   = 1'b0;
    adr_src_o     = 1'b0;
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    reg_write_o   = 1'b0;
    result_src_o  = 2'b00;
    alu_src_a_o   = 2'b00;
    alu_src_b_o   = 2'b00;
    alu_control_o = 3'b000;
    illegal_o     = 1'b0;
    case (state)
      FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
      end
      DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
      end
      MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
      end
      MEMREAD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
      end
      MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
      end
      MEMWRITE: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        adr_src_o   = 1'b1;
      end
      EXECR: begin
        alu_src_a_o   = 2'b10;
        alu_control_o = (funct3_i == 3'b000 && funct7b5_i) ? 3'b001 : alu_f3;
      end
      EXECI: begin
        alu_src_a_o   = 2'b10;
        alu_src_b_o   = 2'b01;
        alu_control_o = alu_f3;
      end
      ALUWB: reg_write_o = 1'b1;
      BEQ: begin
        alu_src_a_o   = 2'b10;
        alu_control_o = 3'b001;
        pc_write_o    = zero_i;
      end
      JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
      end
      LUI: begin
        alu_src_a_o = 2'b11;
        alu_src_b_o = 2'b01;
      end
      TRAP: illegal_o = 1'b1;
      default: illegal_o = 1'b0;
    endcase
  end
  always_comb
    imm_src_o = (op_i == 7'b0000011 || op_i == 7'b0010011) ? 3'b000 :
                op_i == 7'b0100011 ? 3'b001 :
                op_i == 7'b1100011 ? 3'b010 :
                op_i == 7'b1101111 ? 3'b011 :
                op_i == 7'b0110111 ? 3'b100 : 3'b000;
  assign retire = state_next == FETCH &&
                  (state == MEMWB || state == MEMWRITE || state == ALUWB || state == BEQ);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) instret_o <= '0;
    else if (retire) instret_o <= instret_o + XLen'(1);
endmodule
